md_bitmem_rf: RTL and testbench
===============================

// Module: md_bitmem_rf
// PURPOSE
//  Parametrised 4-D register-file memory (2 unpacked x 2 packed dims) with per-field address decode.
//  Adds to the single-bit, async-read test memory: DATA_W-wide leaves, arbitrary (non-pow2) dims,
//  registered read with valid strobe, range checking, and a sequential clear sweep on reset/clear_i.
//  Used as the parametrised storage primitive for multi-dim arrays in the sv2v regression designs.
// PARAMETERS
//  DIM0      2  size of unpacked dim 0 (outermost), indexed by address field 0
//  DIM1      2  size of unpacked dim 1, address field 1
//  DIM2      2  size of packed dim 2, address field 2
//  DIM3      2  size of packed dim 3 (innermost), address field 3
//  DATA_W    1  bits per leaf element
//  CLR_INIT  1  1: run clear sweep after reset; 0: skip to IDLE, contents undefined
//  derived: IWk = max(1,$clog2(DIMk)); ADDR_W = IW0+IW1+IW2+IW3; DEPTH = DIM0*DIM1*DIM2*DIM3
// PORTS
//  clk       in   1       clock, all logic on posedge
//  rst       in   1       synchronous, active-high reset
//  clear_i   in   1       request clear sweep (sampled in IDLE only)
//  wen_i     in   1       write enable
//  waddr_i   in   ADDR_W  write address; field0 in LSBs [IW0-1:0], field3 in MSBs
//  wdata_i   in   DATA_W  write data
//  ren_i     in   1       read request
//  raddr_i   in   ADDR_W  read address, same field layout
//  rdata_o   out  DATA_W  registered read data
//  rvalid_o  out  1       rdata_o/rerr_o valid this cycle
//  rerr_o    out  1       read address out of range
//  rdy_o     out  1       1 in IDLE: reads/writes accepted
// BEHAVIOUR
//  - Reset: rdata_o=0, rvalid_o=0, rerr_o=0, rdy_o=0; state=INIT (CLR_INIT=1) or IDLE (CLR_INIT=0).
//  - FSM INIT: flat counter cnt from 0; each cycle writes 0 to entry cnt (row-major, field0 slowest).
//    cnt==DEPTH-1 -> IDLE next cycle; sweep lasts exactly DEPTH cycles; rdy_o=0 throughout.
//  - IDLE: rdy_o=1. clear_i=1 -> INIT, cnt=0 next cycle; a write/read in that cycle still executes.
//  - INIT ignores wen_i/ren_i: writes dropped, no rvalid_o. rst mid-sweep restarts from cnt=0.
//  - Write: wen_i & rdy_o & all fields in range -> mem[f0][f1][f2][f3] <= wdata_i at posedge.
//    Any field >= its DIM -> write silently dropped; no other entry modified.
//  - Read: ren_i & rdy_o -> next cycle rvalid_o=1; rdata_o=mem[...] and rerr_o=0 if in range,
//    else rdata_o=0, rerr_o=1. Latency 1, one read per cycle, back-to-back allowed, no stall.
//  - No read accepted -> rvalid_o=0 next cycle; rdata_o, rerr_o hold last value.
//  - Same-cycle read and write to same in-range address: write-first, rdata_o = wdata_i.
//  - Field extraction is pure slicing; out-of-range fields never alias (no modulo wrap).
//  - Storage is not reset except by the INIT sweep.
// TESTING
//  1 defaults: rst 1 cycle; rdy_o=0 for 16 cycles, then 1; read all 16 addrs -> rdata_o=0, rerr_o=0
//  2 write addr 4'b1010 data 1, read 4'b1010 next cycle -> rvalid_o=1, rdata_o=1; read 4'b0101 -> 0
//  3 DIM0=3,DATA_W=8: write f0=3 data 8'hA5 -> dropped; read f0=3 -> rerr_o=1, rdata_o=0;
//    read f0=2 (all fields 0) -> 8'h00, rerr_o=0
//  4 DATA_W=8: same-cycle write 8'h3C and read of addr 4'b0011 -> next cycle rdata_o=8'h3C
//  5 fill all 16 with 1, pulse clear_i, rst at sweep cycle 5 -> sweep restarts, rdy_o=0 for
//    16 more cycles, then all reads 0; wen_i/ren_i during sweep -> no rvalid_o, no writes
//  6 CLR_INIT=0: rdy_o=1 first cycle after rst; write/read all 16 addrs with random data -> match

Source files
------------

// File: rtl/md_bitmem_rf.sv
// md_bitmem_rf: parametrised 4-D register-file memory.
//   Storage is r_mem[f0][f1] (unpacked) of [f2][f3] (packed) leaves of DATA_W bits.
//   Address fields are packed with field0 in the LSBs and field3 in the MSBs.
//   Reads are registered (latency 1) with a valid strobe and an out-of-range
//   error flag. A clear sweep zeroes every entry, one per cycle, after reset
//   (when CLR_INIT=1) or on clear_i while idle.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   clear_i                   start a clear sweep (honoured in IDLE only)
//   wen_i, waddr_i, wdata_i   write port
//   ren_i, raddr_i            read request
//   rdata_o, rvalid_o, rerr_o registered read response
//   rdy_o                     1 while accesses are accepted
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_INIT | clear sweep: zero one entry per cycle, accesses ignored
// ST_IDLE | normal operation, reads/writes accepted once rdy_o is 1
module md_bitmem_rf #(
   parameter int DIM0     = 2,
   parameter int DIM1     = 2,
   parameter int DIM2     = 2,
   parameter int DIM3     = 2,
   parameter int DATA_W   = 1,
   parameter int CLR_INIT = 1,
   localparam int IW0     = (DIM0 > 1) ? $clog2(DIM0) : 1,
   localparam int IW1     = (DIM1 > 1) ? $clog2(DIM1) : 1,
   localparam int IW2     = (DIM2 > 1) ? $clog2(DIM2) : 1,
   localparam int IW3     = (DIM3 > 1) ? $clog2(DIM3) : 1,
   localparam int ADDR_W  = IW0 + IW1 + IW2 + IW3,
   localparam int DEPTH   = DIM0 * DIM1 * DIM2 * DIM3,
   localparam int CW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear_i,
   input  logic              wen_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              ren_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rvalid_o,
   output logic              rerr_o,
   output logic              rdy_o
);

   typedef enum logic {ST_INIT, ST_IDLE} state_t;

   logic [DIM2-1:0][DIM3-1:0][DATA_W-1:0] r_mem [DIM0][DIM1];

   state_t            r_state;
   logic              r_rdy;
   logic [DATA_W-1:0] r_rdata;
   logic              r_rvalid;
   logic              r_rerr;
   logic [CW-1:0]     r_rem;
   logic [IW0-1:0]    r_c0;
   logic [IW1-1:0]    r_c1;
   logic [IW2-1:0]    r_c2;
   logic [IW3-1:0]    r_c3;

   logic [IW0-1:0]    w_c0_nxt, w_wf0, w_rf0;
   logic [IW1-1:0]    w_c1_nxt, w_wf1, w_rf1;
   logic [IW2-1:0]    w_c2_nxt, w_wf2, w_rf2;
   logic [IW3-1:0]    w_c3_nxt, w_wf3, w_rf3;
   logic              w_w_inr, w_r_inr, w_wr_go, w_rd_go;
   logic [DATA_W-1:0] w_rd_data;

   // pure slicing; out-of-range field values are rejected, never wrapped
   assign w_wf0 = waddr_i[IW0-1:0];
   assign w_wf1 = waddr_i[IW0 +: IW1];
   assign w_wf2 = waddr_i[IW0+IW1 +: IW2];
   assign w_wf3 = waddr_i[ADDR_W-1 -: IW3];
   assign w_rf0 = raddr_i[IW0-1:0];
   assign w_rf1 = raddr_i[IW0 +: IW1];
   assign w_rf2 = raddr_i[IW0+IW1 +: IW2];
   assign w_rf3 = raddr_i[ADDR_W-1 -: IW3];

   assign w_w_inr = (32'(w_wf0) < 32'(DIM0)) && (32'(w_wf1) < 32'(DIM1)) &&
                    (32'(w_wf2) < 32'(DIM2)) && (32'(w_wf3) < 32'(DIM3));
   assign w_r_inr = (32'(w_rf0) < 32'(DIM0)) && (32'(w_rf1) < 32'(DIM1)) &&
                    (32'(w_rf2) < 32'(DIM2)) && (32'(w_rf3) < 32'(DIM3));

   // r_rdy is only ever 1 in ST_IDLE, so it alone gates accesses
   assign w_wr_go = wen_i & r_rdy & w_w_inr;
   assign w_rd_go = ren_i & r_rdy;

   // write-first bypass for a same-cycle write to the address being read
   assign w_rd_data = (w_wr_go && (waddr_i == raddr_i)) ? wdata_i
                                                          : r_mem[w_rf0][w_rf1][w_rf2][w_rf3];

   // sweep odometer: field3 fastest, field0 slowest (row-major)
   always_comb begin
      w_c0_nxt = r_c0;
      w_c1_nxt = r_c1;
      w_c2_nxt = r_c2;
      w_c3_nxt = r_c3 + IW3'(1);
      if (r_c3 == IW3'(DIM3 - 1)) begin
         w_c3_nxt = '0;
         w_c2_nxt = r_c2 + IW2'(1);
         if (r_c2 == IW2'(DIM2 - 1)) begin
            w_c2_nxt = '0;
            w_c1_nxt = r_c1 + IW1'(1);
            if (r_c1 == IW1'(DIM1 - 1)) begin
               w_c1_nxt = '0;
               w_c0_nxt = r_c0 + IW0'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= (CLR_INIT != 0) ? ST_INIT : ST_IDLE;
         r_rdy    <= 1'b0;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_rerr   <= 1'b0;
         r_rem    <= CW'(DEPTH - 1);
         r_c0     <= '0;
         r_c1     <= '0;
         r_c2     <= '0;
         r_c3     <= '0;
      end else begin
         r_rvalid <= w_rd_go;
         if (w_rd_go) begin
            r_rdata <= w_r_inr ? w_rd_data : '0;
            r_rerr  <= ~w_r_inr;
         end
         case (r_state)
            ST_INIT: begin
               r_c0 <= w_c0_nxt;
               r_c1 <= w_c1_nxt;
               r_c2 <= w_c2_nxt;
               r_c3 <= w_c3_nxt;
               if (r_rem == '0) begin
                  r_state <= ST_IDLE;
                  r_rdy   <= 1'b1;
               end else begin
                  r_rem <= r_rem - CW'(1);
               end
            end
            default: begin
               if (clear_i) begin
                  r_state <= ST_INIT;
                  r_rdy   <= 1'b0;
                  r_rem   <= CW'(DEPTH - 1);
                  r_c0    <= '0;
                  r_c1    <= '0;
                  r_c2    <= '0;
                  r_c3    <= '0;
               end else begin
                  r_rdy <= 1'b1;
               end
            end
         endcase
      end
   end

   // storage has no reset; only the sweep clears it
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (r_state == ST_INIT)
            r_mem[r_c0][r_c1][r_c2][r_c3] <= '0;
         else if (w_wr_go)
            r_mem[w_wf0][w_wf1][w_wf2][w_wf3] <= wdata_i;
      end
   end

   assign rdata_o  = r_rdata;
   assign rvalid_o = r_rvalid;
   assign rerr_o   = r_rerr;
   assign rdy_o    = r_rdy;

endmodule

// File: tb/tb_md_bitmem_rf.sv
module tb_md_bitmem_rf;

   logic       clk = 1'b0;
   logic       rst     [3];
   logic       clear   [3];
   logic       wen     [3];
   logic       ren     [3];
   logic [4:0] waddr   [3];
   logic [4:0] raddr   [3];
   logic [7:0] wdata   [3];

   logic       rd_a, rv_a, re_a, ry_a;
   logic [7:0] rd_b, rd_c;
   logic       rv_b, re_b, ry_b, rv_c, re_c, ry_c;
   logic [2:0] rvalid_w, rerr_w;
   logic [7:0] rdata_w [3];

   always #5 clk = ~clk;

   // A: defaults (4-bit address, 1-bit data)
   md_bitmem_rf u_a (
      .clk(clk), .rst(rst[0]), .clear_i(clear[0]), .wen_i(wen[0]),
      .waddr_i(waddr[0][3:0]), .wdata_i(wdata[0][0:0]), .ren_i(ren[0]),
      .raddr_i(raddr[0][3:0]), .rdata_o(rd_a), .rvalid_o(rv_a), .rerr_o(re_a), .rdy_o(ry_a));

   // B: DIM0=3, 8-bit data (5-bit address, field0 = bits [1:0])
   md_bitmem_rf #(.DIM0(3), .DATA_W(8)) u_b (
      .clk(clk), .rst(rst[1]), .clear_i(clear[1]), .wen_i(wen[1]),
      .waddr_i(waddr[1]), .wdata_i(wdata[1]), .ren_i(ren[1]),
      .raddr_i(raddr[1]), .rdata_o(rd_b), .rvalid_o(rv_b), .rerr_o(re_b), .rdy_o(ry_b));

   // C: 8-bit data, no clear sweep after reset
   md_bitmem_rf #(.DATA_W(8), .CLR_INIT(0)) u_c (
      .clk(clk), .rst(rst[2]), .clear_i(clear[2]), .wen_i(wen[2]),
      .waddr_i(waddr[2][3:0]), .wdata_i(wdata[2]), .ren_i(ren[2]),
      .raddr_i(raddr[2][3:0]), .rdata_o(rd_c), .rvalid_o(rv_c), .rerr_o(re_c), .rdy_o(ry_c));

   assign rvalid_w   = {rv_c, rv_b, rv_a};
   assign rerr_w     = {re_c, re_b, re_a};
   assign rdata_w[0] = {7'b0, rd_a};
   assign rdata_w[1] = rd_b;
   assign rdata_w[2] = rd_c;

   typedef struct {
      int         dut;
      logic [7:0] d;
      logic       e;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: every read response is matched against the oldest expectation
   always @(negedge clk) begin
      for (int d = 0; d < 3; d++) begin
         if (rvalid_w[d] === 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rvalid: dut %0d got rvalid=1 expected none", d);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rd_dut", 32'(d), 32'(e.dut));
               chk($sformatf("rd_data dut%0d", d), 32'(rdata_w[d]), 32'(e.d));
               chk($sformatf("rd_err dut%0d", d), 32'(rerr_w[d]), 32'(e.e));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int d, input logic [4:0] a, input logic [7:0] v);
      wen[d] = 1'b1; waddr[d] = a; wdata[d] = v;
      tick();
      wen[d] = 1'b0;
   endtask

   task automatic rd(input int d, input logic [4:0] a, input logic [7:0] ed, input logic ee);
      ren[d] = 1'b1; raddr[d] = a;
      sb.push_back('{d, ed, ee});
      tick();
      ren[d] = 1'b0;
   endtask

   task automatic wrd(input int d, input logic [4:0] a, input logic [7:0] v);
      wen[d] = 1'b1; waddr[d] = a; wdata[d] = v;
      ren[d] = 1'b1; raddr[d] = a;
      sb.push_back('{d, v, 1'b0});
      tick();
      wen[d] = 1'b0; ren[d] = 1'b0;
   endtask

   // counts sampled cycles with rdy_o low, starting at the current sample
   task automatic count_busy(input int d, output int n);
      logic [2:0] ry;
      n = 0;
      ry = {ry_c, ry_b, ry_a};
      while (ry[d] !== 1'b1 && n < 80) begin
         n++;
         tick();
         ry = {ry_c, ry_b, ry_a};
      end
   endtask

   logic [7:0] mdl [16];
   int         n;

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; clear[d] = 1'b0; wen[d] = 1'b0; ren[d] = 1'b0;
         waddr[d] = '0; raddr[d] = '0; wdata[d] = '0;
      end
      tick();
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;

      // 1: reset state, sweep length, contents cleared
      chk("reset_rdy", 32'(ry_a), 0);
      chk("reset_rvalid", 32'(rv_a), 0);
      chk("reset_rdata", 32'(rd_a), 0);
      chk("reset_rerr", 32'(re_a), 0);
      tick();
      chk("noinit_rdy_first_cycle", 32'(ry_c), 1);
      count_busy(0, n);
      chk("init_sweep_cycles", 32'(n + 1), 16);
      for (int i = 0; i < 16; i++) rd(0, 5'(i), 8'h00, 1'b0);

      // 2: single-bit write/read
      wr(0, 5'b01010, 8'h01);
      rd(0, 5'b01010, 8'h01, 1'b0);
      rd(0, 5'b00101, 8'h00, 1'b0);

      // clear_i sweep from IDLE
      clear[0] = 1'b1;
      tick();
      clear[0] = 1'b0;
      count_busy(0, n);
      chk("clear_sweep_cycles", 32'(n), 16);
      rd(0, 5'b01010, 8'h00, 1'b0);

      // 3: non-pow2 field0 range checking
      count_busy(1, n);
      chk("b_ready", 32'(ry_b), 1);
      wr(1, 5'b00011, 8'hA5);
      rd(1, 5'b00011, 8'h00, 1'b1);
      rd(1, 5'b00010, 8'h00, 1'b0);
      wr(1, 5'b10010, 8'h5A);
      rd(1, 5'b10010, 8'h5A, 1'b0);
      rd(1, 5'b10011, 8'h00, 1'b1);
      for (int i = 0; i < 32; i++)
         if ((i & 3) != 3 && i != 5'b10010) rd(1, 5'(i), 8'h00, 1'b0);

      // 4: write-first on same-cycle read/write, then hold when idle
      wr(2, 5'b00011, 8'h11);
      wrd(2, 5'b00011, 8'h3C);
      tick();
      chk("hold_rvalid", 32'(rv_c), 0);
      chk("hold_rdata", 32'(rd_c), 32'h3C);
      chk("hold_rerr", 32'(re_c), 0);

      // 6: CLR_INIT=0 random fill and readback
      for (int i = 0; i < 16; i++) begin
         mdl[i] = 8'($urandom);
         wr(2, 5'(i), mdl[i]);
      end
      for (int i = 0; i < 16; i++) rd(2, 5'(i), mdl[i], 1'b0);

      // 5: fill with ones, clear, reset mid-sweep; accesses during sweep ignored
      for (int i = 0; i < 16; i++) wr(0, 5'(i), 8'h01);
      rd(0, 5'b01111, 8'h01, 1'b0);
      clear[0] = 1'b1;
      tick();
      clear[0] = 1'b0;
      wen[0] = 1'b1; ren[0] = 1'b1; wdata[0] = 8'h01;
      for (int i = 0; i < 5; i++) begin
         waddr[0] = 5'(i); raddr[0] = 5'(i);
         tick();
      end
      chk("sweep_rdy_low", 32'(ry_a), 0);
      rst[0] = 1'b1;
      tick();
      rst[0] = 1'b0;
      waddr[0] = 5'b01100; raddr[0] = 5'b01100;
      count_busy(0, n);
      wen[0] = 1'b0; ren[0] = 1'b0;
      chk("restart_sweep_cycles", 32'(n), 16);
      for (int i = 0; i < 16; i++) rd(0, 5'(i), 8'h00, 1'b0);

      tick();
      tick();
      chk("scoreboard_drained", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
